// File: rtl/mux_arbiter_2_if.sv
// Handshake/data bundle between two requesting masters and mux_arbiter_2.
// The slave modport is the arbiter side and the master modport is the requester side.
interface mux_arbiter_2_if #(
  parameter int W = 8
);
  logic [1:0]   req;
  logic [W-1:0] D0;
  logic [W-1:0] D1;
  logic [1:0]   gnt;
  logic         sel;
  logic [W-1:0] y;
  logic         y_valid;
  logic         busy;

  modport master (
    output req, D0, D1,
    input  gnt, sel, y, y_valid, busy
  );

  modport slave (
    input  req, D0, D1,
    output gnt, sel, y, y_valid, busy
  );
endinterface

// File: rtl/mux_arbiter_2.sv
// Two-master round-robin arbiter that owns the select of a shared 2:1 data mux.
// The optional hold-limit rotation is enabled by defining ARB_TIMEOUT_EN.
module mux_arbiter_2 #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input logic            clk,
  input logic            rst_n,
  mux_arbiter_2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_last;
  logic         r_sel;
  logic         r_busy;
  logic         w_to0;
  logic         w_to1;
  logic [W-1:0] w_y;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 2..255");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LP_LIM = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;

  // Forced rotation only when the other master is actually waiting
  assign w_to0 = (r_hold_cnt == LP_LIM) & bus.req[1];
  assign w_to1 = (r_hold_cnt == LP_LIM) & bus.req[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 8'd0;
    end else if (w_next != r_state) begin
      r_hold_cnt <= 8'd0;
    end else if (r_state != IDLE && r_hold_cnt != LP_LIM) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end
`else
  assign w_to0 = 1'b0;
  assign w_to1 = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.req == 2'b11) begin
          w_next = r_last ? G0 : G1;
        end else if (bus.req[0]) begin
          w_next = G0;
        end else if (bus.req[1]) begin
          w_next = G1;
        end
      end
      G0: begin
        if (!bus.req[0]) begin
          w_next = bus.req[1] ? G1 : IDLE;
        end else if (w_to0) begin
          w_next = G1;
        end
      end
      G1: begin
        if (!bus.req[1]) begin
          w_next = bus.req[0] ? G0 : IDLE;
        end else if (w_to1) begin
          w_next = G0;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // sel and last only move on grant entry; IDLE keeps the previous select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      if (w_next == G0) begin
        r_last <= 1'b0;
        r_sel  <= 1'b0;
      end else if (w_next == G1) begin
        r_last <= 1'b1;
        r_sel  <= 1'b1;
      end
    end
  end

  assign w_y         = r_sel ? bus.D1 : bus.D0;
  assign bus.gnt     = r_state;
  assign bus.sel     = r_sel;
  assign bus.busy    = r_busy;
  assign bus.y       = w_y;
  assign bus.y_valid = |(r_state & bus.req);

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Scoreboard bench for mux_arbiter_2: directed vectors push expectations,
// a monitor pops them after each clock edge or reset assertion.
module tb_mux_arbiter_2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mux_arbiter_2_if #(.W(8)) bus ();

  mux_arbiter_2 #(
    .W        (8),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] gnt;
    logic       sel;
    logic       busy;
    logic [7:0] y;
    logic       yv;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic push(input logic [1:0] g, input logic s, input logic bz);
    exp_t e;
    e.gnt  = g;
    e.sel  = s;
    e.busy = bz;
    e.y    = s ? bus.D1 : bus.D0;
    e.yv   = |(g & bus.req);
    sbq.push_back(e);
  endtask

  task automatic vec(input logic [1:0] r, input logic [7:0] a,
                     input logic [7:0] b, input logic [1:0] g,
                     input logic s, input logic bz);
    @(negedge clk);
    bus.req = r;
    bus.D0  = a;
    bus.D1  = b;
    push(g, s, bz);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    push(2'b00, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic mid_rst();
    @(posedge clk);
    #3;
    push(2'b00, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    bus.req = 2'b00;
    rst_n   = 1'b1;
  endtask

  initial begin
    forever begin
      exp_t e;
      exp_t a;
      @(posedge clk or negedge rst_n);
      #1;
      if (sbq.size() > 0) begin
        e      = sbq.pop_front();
        a.gnt  = bus.gnt;
        a.sel  = bus.sel;
        a.busy = bus.busy;
        a.y    = bus.y;
        a.yv   = bus.y_valid;
        n_chk++;
        if (a === e) begin
          n_pass++;
        end else begin
          $display("FAIL chk%0d gnt/sel/busy/y/yv got %b/%b/%b/%h/%b want %b/%b/%b/%h/%b",
                   n_chk, a.gnt, a.sel, a.busy, a.y, a.yv,
                   e.gnt, e.sel, e.busy, e.y, e.yv);
        end
      end
    end
  end

  initial begin
    logic [1:0] g;
    logic       s;
    bus.req = 2'b00;
    bus.D0  = 8'h00;
    bus.D1  = 8'h00;
    #3;
    push(2'b00, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single requester grant and release
    vec(2'b01, 8'hA5, 8'h3C, 2'b01, 1'b0, 1'b1);
    vec(2'b00, 8'hA5, 8'h3C, 2'b00, 1'b0, 1'b0);

    // contention from reset, then direct handoff, sel held in IDLE
    rst_pulse();
    vec(2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 1'b1);
    vec(2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 1'b1);
    vec(2'b10, 8'h11, 8'h22, 2'b10, 1'b1, 1'b1);
    vec(2'b00, 8'h11, 8'h22, 2'b00, 1'b1, 1'b0);

    // round robin between contentions
    vec(2'b01, 8'h33, 8'h44, 2'b01, 1'b0, 1'b1);
    vec(2'b00, 8'h33, 8'h44, 2'b00, 1'b0, 1'b0);
    vec(2'b11, 8'h33, 8'h44, 2'b10, 1'b1, 1'b1);
    vec(2'b00, 8'h33, 8'h44, 2'b00, 1'b1, 1'b0);
    vec(2'b11, 8'h33, 8'h44, 2'b01, 1'b0, 1'b1);
    vec(2'b00, 8'h33, 8'h44, 2'b00, 1'b0, 1'b0);

    // waiting master, handoff, simultaneous release plus new request
    vec(2'b01, 8'h55, 8'h66, 2'b01, 1'b0, 1'b1);
    vec(2'b11, 8'h55, 8'h66, 2'b01, 1'b0, 1'b1);
    vec(2'b11, 8'h55, 8'h66, 2'b01, 1'b0, 1'b1);
    vec(2'b10, 8'h55, 8'h66, 2'b10, 1'b1, 1'b1);
    vec(2'b01, 8'h55, 8'h66, 2'b01, 1'b0, 1'b1);
    vec(2'b00, 8'h55, 8'h66, 2'b00, 1'b0, 1'b0);

    // long contention: rotation with hold limit, none without
    rst_pulse();
`ifdef ARB_TIMEOUT_EN
    s = 1'b0;
    for (int i = 0; i < 24; i++) begin
      s = ((i / 4) % 2) == 1;
      g = s ? 2'b10 : 2'b01;
      vec(2'b11, 8'h77, 8'h88, g, s, 1'b1);
    end
`else
    s = 1'b0;
    for (int i = 0; i < 50; i++) begin
      vec(2'b11, 8'h77, 8'h88, 2'b01, 1'b0, 1'b1);
    end
`endif
    vec(2'b00, 8'h77, 8'h88, 2'b00, s, 1'b0);
    for (int i = 0; i < 25; i++) begin
      vec(2'b01, 8'h77, 8'h88, 2'b01, 1'b0, 1'b1);
    end

    // asynchronous reset while master 1 holds the grant
    vec(2'b10, 8'h99, 8'hAA, 2'b10, 1'b1, 1'b1);
    mid_rst();
    vec(2'b11, 8'h99, 8'hAA, 2'b01, 1'b0, 1'b1);
    vec(2'b00, 8'h99, 8'hAA, 2'b00, 1'b0, 1'b0);

    for (int k = 0; k < 20 && sbq.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time %0t reached, want finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
